// File: rtl/upsample_read_scheduler_pkg.sv
// Shared types and defaults for the upsample FIFO read scheduler.
// Each input row is read twice: once through the virtual pointer and once through the real pointer.
package upsample_read_scheduler_pkg;

    localparam int DATA_R_DEF  = 128;
    localparam int DEPTH_R_DEF = 11;
    localparam int ROWS_W_DEF  = 10;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD0  = 3'd1,
        SW0  = 3'd2,
        GAP0 = 3'd3,
        RD1  = 3'd4,
        SW1  = 3'd5,
        GAP1 = 3'd6,
        FIN  = 3'd7
    } state_t;

    function automatic logic is_read_state(input state_t s);
        return (s == RD0) || (s == RD1);
    endfunction

    function automatic logic is_switch_state(input state_t s);
        return (s == SW0) || (s == SW1);
    endfunction

endpackage

// File: rtl/upsample_read_scheduler_row_counter.sv
// Column/row counter pair for the read scheduler, with last-word and last-row flags
// compared against the latched frame configuration.
module upsample_row_counter #(
    parameter int COL_W = 11,
    parameter int ROW_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             col_en,
    input  logic             row_en,
    input  logic [COL_W-1:0] row_words,
    input  logic [ROW_W-1:0] row_num,
    output logic [COL_W-1:0] col_cnt,
    output logic             col_last,
    output logic             row_last
);

    localparam logic [COL_W-1:0] COL_ONE = COL_W'(1);
    localparam logic [ROW_W-1:0] ROW_ONE = ROW_W'(1);

    logic [ROW_W-1:0] row_cnt;

    // The column counter wraps to zero on the last word so both passes of a row start aligned.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_cnt <= '0;
        end else if (load) begin
            col_cnt <= '0;
        end else if (col_en) begin
            if (col_last) begin
                col_cnt <= '0;
            end else begin
                col_cnt <= col_cnt + COL_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_cnt <= '0;
        end else if (load) begin
            row_cnt <= '0;
        end else if (row_en) begin
            row_cnt <= row_cnt + ROW_ONE;
        end
    end

    assign col_last = (col_cnt == (row_words - COL_ONE));
    assign row_last = (row_cnt == (row_num - ROW_ONE));

endmodule

// File: rtl/upsample_read_scheduler.sv
// Read-side controller for the upsample FIFO: 2x vertical nearest-neighbour upsampling by
// reading each row via the virtual pointer, switching, then re-reading via the real pointer.
module upsample_read_scheduler
    import upsample_read_scheduler_pkg::*;
#(
    parameter int DATA_R  = DATA_R_DEF,
    parameter int DEPTH_R = DEPTH_R_DEF,
    parameter int ROWS_W  = ROWS_W_DEF
) (
    input  logic               system_clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic [DEPTH_R-1:0] i_row_words,
    input  logic [ROWS_W-1:0]  i_row_num,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_fifo_rden,
    output logic               o_fifo_change_point,
    output logic [DEPTH_R-1:0] o_fifo_almost_empty_threshold,
    input  logic               i_fifo_hold,
    input  logic [DATA_R-1:0]  i_fifo_rddata,
    output logic [DATA_R-1:0]  o_data,
    output logic               o_valid,
    input  logic               i_ready,
    output logic               o_last,
    output logic               o_pass,
    output state_t             dbg_state,
    output logic               dbg_ptr_sel,
    output logic [DEPTH_R-1:0] dbg_col_cnt
);

    // Stream handshake: a word transfers in any cycle with o_valid && i_ready; o_valid never
    // depends on i_ready, and o_data/o_last/o_pass hold steady while o_valid && !i_ready.

    state_t             state;
    state_t             state_nx;
    logic [DEPTH_R-1:0] row_words_q;
    logic [ROWS_W-1:0]  row_num_q;
    logic               ptr_sel_q;
    logic [DEPTH_R-1:0] col_cnt;
    logic               col_last;
    logic               row_last;
    logic               load;
    logic               row_en;
    logic               valid;
    logic               rden;

    assign load   = (state == IDLE) && i_start;
    assign row_en = (state == GAP1);
    assign valid  = is_read_state(state) && !i_fifo_hold;
    assign rden   = valid && i_ready;

    upsample_row_counter #(
        .COL_W(DEPTH_R),
        .ROW_W(ROWS_W)
    ) u_row_counter (
        .clk      (system_clk),
        .rst_n    (rst_n),
        .load     (load),
        .col_en   (rden),
        .row_en   (row_en),
        .row_words(row_words_q),
        .row_num  (row_num_q),
        .col_cnt  (col_cnt),
        .col_last (col_last),
        .row_last (row_last)
    );

    always_ff @(posedge system_clk) begin
        if (!rst_n) begin
            row_words_q <= '0;
            row_num_q   <= '0;
        end else if (load) begin
            row_words_q <= i_row_words;
            row_num_q   <= i_row_num;
        end
    end

    // Mirrors the FIFO's pointer_select so the two never disagree after a switch.
    always_ff @(posedge system_clk) begin
        if (!rst_n) begin
            ptr_sel_q <= 1'b0;
        end else if (state == SW0) begin
            ptr_sel_q <= 1'b1;
        end else if (state == SW1) begin
            ptr_sel_q <= 1'b0;
        end
    end

    always_ff @(posedge system_clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (i_start) begin
                    if ((i_row_words == '0) || (i_row_num == '0)) begin
                        state_nx = FIN;
                    end else begin
                        state_nx = RD0;
                    end
                end
            end
            RD0: begin
                if (rden && col_last) begin
                    state_nx = SW0;
                end
            end
            SW0:  state_nx = GAP0;
            GAP0: state_nx = RD1;
            RD1: begin
                if (rden && col_last) begin
                    state_nx = SW1;
                end
            end
            SW1:  state_nx = GAP1;
            GAP1: begin
                if (row_last) begin
                    state_nx = FIN;
                end else begin
                    state_nx = RD0;
                end
            end
            FIN:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        o_busy                        = (state != IDLE);
        o_done                        = (state == FIN);
        o_fifo_change_point           = is_switch_state(state);
        o_valid                       = valid;
        o_fifo_rden                   = rden;
        o_last                        = valid && col_last;
        o_pass                        = (state == RD1);
        o_fifo_almost_empty_threshold = row_words_q;
    end

    assign o_data      = i_fifo_rddata;
    assign dbg_state   = state;
    assign dbg_ptr_sel = ptr_sel_q;
    assign dbg_col_cnt = col_cnt;

endmodule
